// File: rtl/pipeline_credit_pkg.sv
// Shared types and sizing helpers for the credit-controlled pipeline sink.
// Imported by the result FIFO and the top-level credit logic.
package pipeline_credit_pkg;

    // Width needed to hold values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Flush countdown register width; bounds the supported pipeline latency.
    localparam int FLUSH_W = 8;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_UNEXPECTED,
        ERR_OVERFLOW
    } err_cause_e;

endpackage

// File: rtl/sync_fifo_regs.sv
// Flop-based synchronous FIFO with occupancy count.
// Read data is the registered head entry; a write is never bypassed to the read port.
module sync_fifo_regs
    import pipeline_credit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW = cnt_width(DEPTH),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointer and occupancy tracking; push and pop together leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pipeline_credit_sink.sv
// Consumer end of a non-stalling fixed-latency pipeline.
// Credits cover in-flight plus buffered results so no result can be lost.
module pipeline_credit_sink
    import pipeline_credit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int RESULT_WIDTH = 32,
    parameter int PIPE_LATENCY = 1,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   req_data,
    output logic                    pipe_in_valid,
    output logic [DATA_WIDTH-1:0]   pipe_in_data,
    input  logic                    pipe_out_valid,
    input  logic [RESULT_WIDTH-1:0] pipe_out_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [RESULT_WIDTH-1:0] resp_data,
    output logic                    err
);

    localparam int CW  = cnt_width(DEPTH);
    localparam int CRW = CW + 1;
    localparam logic [CRW-1:0] DEPTH_C = CRW'(DEPTH);

    logic [CW-1:0]      inflight;
    logic [CW-1:0]      count;
    logic [FLUSH_W-1:0] flush;
    logic [CRW-1:0]     credits;
    logic               flushing;
    logic               issue;
    logic               accept;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    err_cause_e         err_cause;

    // Extra bit so a broken invariant shows up as a large value, not a wrap to small.
    assign credits  = DEPTH_C - CRW'(inflight) - CRW'(count);
    assign flushing = (flush != '0);

    assign req_ready     = rst_n & ~flushing & (credits != '0);
    assign issue         = req_valid & req_ready;
    assign pipe_in_valid = issue;
    assign pipe_in_data  = req_data;

    assign resp_valid = rst_n & ~empty;
    assign pop        = resp_valid & resp_ready;
    assign accept     = pipe_out_valid & ~flushing;

    // Classify each accepted result; anything but ERR_NONE is dropped.
    always_comb begin
        err_cause = ERR_NONE;
        if (accept) begin
            if (inflight == '0)   err_cause = ERR_UNEXPECTED;
            else if (full && !pop) err_cause = ERR_OVERFLOW;
        end
    end

    assign push = accept & (err_cause == ERR_NONE);

    // In-flight tracking, post-reset flush countdown and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
            flush    <= FLUSH_W'(PIPE_LATENCY);
            err      <= 1'b0;
        end else begin
            if (flushing) flush <= flush - 1'b1;
            if (issue && !(accept && inflight != '0))
                inflight <= inflight + 1'b1;
            else if (!issue && accept && inflight != '0)
                inflight <= inflight - 1'b1;
            if (err_cause != ERR_NONE) err <= 1'b1;
        end
    end

    sync_fifo_regs #(
        .WIDTH (RESULT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (pipe_out_data),
        .rdata (resp_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    a_credit_bound: assert property (
        @(posedge clk) disable iff (!rst_n) credits <= DEPTH_C);

    a_issue_has_credit: assert property (
        @(posedge clk) disable iff (!rst_n) issue |-> credits != '0);

    a_err_sticks: assert property (
        @(posedge clk) disable iff (!rst_n) (err_cause != ERR_NONE) |=> err);

endmodule

// File: tb/tb_pipeline_credit_sink.sv
// Bench for pipeline_credit_sink wrapped around a 1-stage a+b pipeline.
// A queue-based reference model predicts readiness, results and errors.
module tb_pipeline_credit_sink;

    localparam int DW    = 64;
    localparam int RW    = 32;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_data;
    logic          pipe_in_valid;
    logic [DW-1:0] pipe_in_data;
    logic          pipe_out_valid;
    logic [RW-1:0] pipe_out_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [RW-1:0] resp_data;
    logic          err;

    logic [31:0] a;
    logic [31:0] b;
    logic        p_valid = 1'b0;
    logic [31:0] p_data  = '0;
    logic        force_v = 1'b0;
    logic [31:0] force_d = '0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_pend  = 0;
    logic [31:0] mbuf[$];
    int          m_flush = LAT;
    bit          m_err   = 1'b0;
    bit          m_sv    = 1'b0;
    logic [31:0] m_sd    = '0;

    always #5 clk = ~clk;

    assign req_data = {a, b};

    // The wrapped pipeline: one register stage computing a+b, never reset.
    always @(posedge clk) begin
        p_valid <= pipe_in_valid;
        p_data  <= pipe_in_data[63:32] + pipe_in_data[31:0];
    end

    assign pipe_out_valid = p_valid | force_v;
    assign pipe_out_data  = force_v ? force_d : p_data;

    pipeline_credit_sink #(
        .DATA_WIDTH   (DW),
        .RESULT_WIDTH (RW),
        .PIPE_LATENCY (LAT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .pipe_in_valid  (pipe_in_valid),
        .pipe_in_data   (pipe_in_data),
        .pipe_out_valid (pipe_out_valid),
        .pipe_out_data  (pipe_out_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .err            (err)
    );

    function automatic bit exp_ready();
        return (rst_n === 1'b1) && (m_flush == 0)
            && ((m_pend + mbuf.size()) < DEPTH);
    endfunction

    function automatic bit exp_rv();
        return (rst_n === 1'b1) && (mbuf.size() != 0);
    endfunction

    // Advance the model by one clock using the inputs now applied, then step the DUT.
    task automatic tick();
        bit          rdy;
        bit          iss;
        bit          pp;
        bit          arr;
        logic [31:0] ad;
        rdy = exp_ready();
        iss = (req_valid === 1'b1) && rdy;
        pp  = exp_rv() && (resp_ready === 1'b1);
        arr = m_sv || force_v;
        ad  = force_v ? force_d : m_sd;
        if (rst_n !== 1'b1) begin
            m_pend  = 0;
            mbuf.delete();
            m_flush = LAT;
            m_err   = 1'b0;
        end else begin
            if (pp) void'(mbuf.pop_front());
            if (arr && m_flush == 0) begin
                if (m_pend == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_pend--;
                    if (mbuf.size() == DEPTH) m_err = 1'b1;
                    else mbuf.push_back(ad);
                end
            end
            if (m_flush != 0) m_flush--;
            if (iss) m_pend++;
        end
        m_sv = iss;
        m_sd = a + b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; a = 1; b = 2;
        resp_ready = 1'b1; force_v = 1'b0;
        tick(); tick(); #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready);
        end
        checks++;
        if (pipe_in_valid !== 1'b0) begin
            errors++; $display("FAIL reset_pipe_in_valid got %b exp 0", pipe_in_valid);
        end
        checks++;
        if (resp_valid !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got rv=%b err=%b exp 0 0", resp_valid, err);
        end
        rst_n = 1'b1; req_valid = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_flush_ready got %b exp 0", req_ready);
        end
        tick(); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after_flush got %b exp 1", req_ready);
        end
    endtask

    task automatic test_single();
        resp_ready = 1'b1; a = 3; b = 4; req_valid = 1'b1; #1;
        checks++;
        if (pipe_in_valid !== 1'b1 || pipe_in_data !== {32'd3, 32'd4}) begin
            errors++;
            $display("FAIL single_issue got v=%b d=%h exp 1 %h",
                     pipe_in_valid, pipe_in_data, {32'd3, 32'd4});
        end
        tick();
        req_valid = 1'b0; #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_t1_rv got %b exp 0", resp_valid);
        end
        tick(); #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd7) begin
            errors++; $display("FAIL single_t2_resp got v=%b d=%0d exp 1 7", resp_valid, resp_data);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready got %b exp 1", req_ready);
        end
        tick(); #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_popped got %b exp 0", resp_valid);
        end
    endtask

    task automatic test_backpressure();
        int k;
        int issues;
        k = 1; issues = 0;
        resp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = k; b = 0; #1;
            checks++;
            if (pipe_in_valid !== exp_ready()) begin
                errors++;
                $display("FAIL bp_issue cyc %0d got %b exp %b", i, pipe_in_valid, exp_ready());
            end
            if (pipe_in_valid === 1'b1) issues++;
            if (exp_ready()) k++;
            tick();
        end
        req_valid = 1'b0; #1;
        checks++;
        if (issues != DEPTH || req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_fill got issues=%0d rdy=%b exp 4 0", issues, req_ready);
        end
        resp_ready = 1'b1;
        for (int j = 1; j <= DEPTH; j++) begin
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 32'(j)) begin
                errors++; $display("FAIL bp_drain got v=%b d=%0d exp 1 %0d", resp_valid, resp_data, j);
            end
            checks++;
            if (req_ready !== (j != 1)) begin
                errors++; $display("FAIL bp_ready_return pop %0d got %b exp %b", j, req_ready, j != 1);
            end
            tick();
        end
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty got %b exp 0", resp_valid);
        end
    endtask

    task automatic test_stream();
        int sent;
        int got;
        int bubbles;
        sent = 0; got = 0; bubbles = 0;
        resp_ready = 1'b1;
        for (int c = 0; c < 40 && (sent < 16 || mbuf.size() != 0 || m_pend != 0); c++) begin
            req_valid = (sent < 16);
            a = $urandom; b = $urandom; #1;
            checks++;
            if (pipe_in_valid !== (req_valid && exp_ready())) begin
                errors++; $display("FAIL stream_issue cyc %0d got %b", c, pipe_in_valid);
            end
            if (req_valid && pipe_in_valid !== 1'b1) bubbles++;
            checks++;
            if (resp_valid !== exp_rv() || (exp_rv() && resp_data !== mbuf[0])) begin
                errors++;
                $display("FAIL stream_resp cyc %0d got v=%b d=%h exp %b %h",
                         c, resp_valid, resp_data, exp_rv(), exp_rv() ? mbuf[0] : 32'h0);
            end
            if (exp_rv()) got++;
            if (req_valid && exp_ready()) sent++;
            tick();
        end
        checks++;
        if (bubbles != 0 || got != 16 || err !== 1'b0) begin
            errors++;
            $display("FAIL stream_summary got bubbles=%0d out=%0d err=%b exp 0 16 0", bubbles, got, err);
        end
    endtask

    task automatic test_pop_accept();
        bit          found;
        int          pops;
        logic [31:0] h1;
        found = 1'b0;
        resp_ready = 1'b0; req_valid = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            a = $urandom; b = $urandom; #1;
            if (mbuf.size() == DEPTH - 1 && m_pend == 1 && m_sv) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL popacc_setup got not reached exp reached");
        end else begin
            req_valid = 1'b0; resp_ready = 1'b1; #1;
            h1 = mbuf[1];
            checks++;
            if (resp_data !== mbuf[0]) begin
                errors++; $display("FAIL popacc_head got %h exp %h", resp_data, mbuf[0]);
            end
            tick();
            resp_ready = 1'b0; #1;
            checks++;
            if (resp_data !== h1 || err !== 1'b0) begin
                errors++; $display("FAIL popacc_advance got d=%h err=%b exp %h 0", resp_data, err, h1);
            end
        end
        pops = 0;
        resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (resp_valid === 1'b1) begin
                pops++;
                checks++;
                if (resp_data !== mbuf[0]) begin
                    errors++; $display("FAIL popacc_drain got %h exp %h", resp_data, mbuf[0]);
                end
            end
            tick();
        end
        checks++;
        if (pops != DEPTH - 1) begin
            errors++; $display("FAIL popacc_count got %0d exp %0d", pops, DEPTH - 1);
        end
    endtask

    task automatic test_flush();
        resp_ready = 1'b1; a = 5; b = 6; req_valid = 1'b1; #1;
        checks++;
        if (pipe_in_valid !== 1'b1) begin
            errors++; $display("FAIL flush_issue got %b exp 1", pipe_in_valid);
        end
        tick();
        req_valid = 1'b0; rst_n = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL flush_in_reset got rdy=%b rv=%b exp 0 0", req_ready, resp_valid);
        end
        tick();
        rst_n = 1'b1; force_v = 1'b1; force_d = 32'hDEAD_BEEF; #1;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL flush_window got rdy=%b rv=%b exp 0 0", req_ready, resp_valid);
        end
        tick();
        force_v = 1'b0; #1;
        checks++;
        if (resp_valid !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_discard got rv=%b err=%b rdy=%b exp 0 0 1", resp_valid, err, req_ready);
        end
        a = 10; b = 20; req_valid = 1'b1; #1;
        tick();
        req_valid = 1'b0; #1;
        tick(); #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd30) begin
            errors++; $display("FAIL flush_recover got v=%b d=%0d exp 1 30", resp_valid, resp_data);
        end
        tick();
    endtask

    task automatic test_err();
        resp_ready = 1'b1; req_valid = 1'b0;
        force_v = 1'b1; force_d = 32'd77; #1;
        tick();
        force_v = 1'b0; #1;
        checks++;
        if (err !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL err_unexpected got err=%b rv=%b exp 1 0", err, resp_valid);
        end
        a = 1; b = 1; req_valid = 1'b1; #1;
        tick();
        req_valid = 1'b0; #1;
        tick(); #1;
        checks++;
        if (err !== 1'b1 || resp_valid !== 1'b1 || resp_data !== 32'd2) begin
            errors++;
            $display("FAIL err_sticky got err=%b v=%b d=%0d exp 1 1 2", err, resp_valid, resp_data);
        end
        checks++;
        if (err !== m_err) begin
            errors++; $display("FAIL err_model got %b exp %b", err, m_err);
        end
        tick();
        rst_n = 1'b0; #1;
        tick();
        rst_n = 1'b1; #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_cleared got %b exp 0", err);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; a = 0; b = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_pop_accept();
        test_flush();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
